// File: rtl/ls16x_chain.sv
// ls16x_chain: N-stage 74LS160/161/163-style synchronous counter chain.
// Optional LS16X_AUTO_RELOAD_EN: terminal count reloads din (divider mode).
module ls16x_chain #(
  parameter int DIGITS = 2,
  parameter int DECADE = 0
) (
  input  logic                  clk,
  input  logic                  n_clr,
  input  logic                  n_sclr,
  input  logic                  n_load,
  input  logic [4*DIGITS-1:0]   din,
  input  logic                  enp,
  input  logic                  ent,
  input  logic                  up,
  output logic [4*DIGITS-1:0]   q,
  output logic [DIGITS-1:0]     rco,
  output logic                  tc
);

  localparam logic [3:0] MAXV =
    (DECADE != 0) ? 4'd9 : 4'd15;

  logic [DIGITS-1:0] hit;
  logic [DIGITS-1:0] en;
  logic              reload;
  logic              acc;

  // Look-ahead carry: each stage sees the AND of ent and all lower hits
  always_comb begin
    hit = '0;
    en  = '0;
    rco = '0;
    acc = ent;
    for (int i = 0; i < DIGITS; i++) begin
      hit[i] = up ? (q[4*i +: 4] == MAXV)
                  : (q[4*i +: 4] == 4'd0);
      en[i]  = acc;
      acc    = acc & hit[i];
      rco[i] = acc;
    end
  end

  assign tc = rco[DIGITS-1];

`ifdef LS16X_AUTO_RELOAD_EN
  assign reload = enp & tc;
`else
  assign reload = 1'b0;
`endif

  // Out-of-range decade digits fall to 0 going up, 9 going down
  function automatic logic [3:0] step_dig(
    input logic [3:0] v,
    input logic       dir
  );
    logic [3:0] r;
    if (dir) begin
      r = (v >= MAXV) ? 4'd0 : v + 4'd1;
    end else begin
      if (v == 4'd0 || v > MAXV) r = MAXV;
      else                       r = v - 4'd1;
    end
    return r;
  endfunction

  always_ff @(posedge clk or negedge n_clr) begin
    if (!n_clr) begin
      q <= '0;
    end else if (!n_sclr) begin
      q <= '0;
    end else if (!n_load || reload) begin
      q <= din;
    end else begin
      for (int i = 0; i < DIGITS; i++) begin
        if (enp && en[i]) begin
          q[4*i +: 4] <= step_dig(q[4*i +: 4], up);
        end
      end
    end
  end

endmodule

// File: tb/tb_ls16x_chain.sv
// tb_ls16x_chain: directed plan plus randomized run against a
// digit-rule reference model for binary, decade and 1-digit chains.
module tb_ls16x_chain;

`ifdef LS16X_AUTO_RELOAD_EN
  localparam bit AR = 1'b1;
`else
  localparam bit AR = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       n_clr, n_sclr, n_load;
  logic       enp, ent, up;
  logic [7:0] din;

  logic [7:0] q_b, q_d;
  logic [1:0] rco_b, rco_d;
  logic       tc_b, tc_d;
  logic [3:0] q_o;
  logic [0:0] rco_o;
  logic       tc_o;

  logic [7:0] m_b, m_d, m_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  ls16x_chain #(.DIGITS(2), .DECADE(0)) u_bin (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr),
    .n_load(n_load), .din(din), .enp(enp),
    .ent(ent), .up(up), .q(q_b), .rco(rco_b),
    .tc(tc_b)
  );

  ls16x_chain #(.DIGITS(2), .DECADE(1)) u_dec (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr),
    .n_load(n_load), .din(din), .enp(enp),
    .ent(ent), .up(up), .q(q_d), .rco(rco_d),
    .tc(tc_d)
  );

  ls16x_chain #(.DIGITS(1), .DECADE(0)) u_one (
    .clk(clk), .n_clr(n_clr), .n_sclr(n_sclr),
    .n_load(n_load), .din(din[3:0]), .enp(enp),
    .ent(ent), .up(up), .q(q_o), .rco(rco_o),
    .tc(tc_o)
  );

  task automatic chk(
    input string       tag,
    input logic [31:0] got,
    input logic [31:0] exp
  );
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h",
               tag, got, exp);
    end
  endtask

  function automatic int dig(
    input logic [7:0] v, input int i
  );
    return int'((v >> (4*i)) & 8'hF);
  endfunction

  function automatic bit at_term(input int d, input int mx);
    return up ? (d == mx) : (d == 0);
  endfunction

  function automatic logic [1:0] rco_m(
    input logic [7:0] v, input int nd, input int mx
  );
    logic [1:0] r;
    bit c;
    r = '0;
    c = ent;
    for (int i = 0; i < nd; i++) begin
      c = c && at_term(dig(v, i), mx);
      r[i] = c;
    end
    return r;
  endfunction

  function automatic logic [7:0] nxt(
    input logic [7:0] v, input int nd, input int mx,
    input logic [7:0] d
  );
    logic [7:0] r;
    logic [1:0] rc;
    int x;
    bit c;
    if (!n_sclr) return 8'h00;
    if (!n_load) return d;
    rc = rco_m(v, nd, mx);
    if (AR && enp && rc[nd-1]) return d;
    r = '0;
    c = ent;
    for (int i = 0; i < nd; i++) begin
      x = dig(v, i);
      if (enp && c) begin
        if (up) x = (x >= mx) ? 0 : x + 1;
        else    x = (x == 0 || x > mx) ? mx : x - 1;
      end
      c = c && at_term(dig(v, i), mx);
      r = r | (8'(x) << (4*i));
    end
    return r;
  endfunction

  task automatic chk_q();
    chk("q_bin", 32'(q_b), 32'(m_b));
    chk("q_dec", 32'(q_d), 32'(m_d));
    chk("q_one", 32'(q_o), 32'(m_o));
  endtask

  task automatic chk_comb();
    logic [1:0] r;
    #1;
    r = rco_m(m_b, 2, 15);
    chk("rco_bin", 32'(rco_b), 32'(r));
    chk("tc_bin", 32'(tc_b), 32'(r[1]));
    r = rco_m(m_d, 2, 9);
    chk("rco_dec", 32'(rco_d), 32'(r));
    chk("tc_dec", 32'(tc_d), 32'(r[1]));
    r = rco_m(m_o, 1, 15);
    chk("rco_one", 32'(rco_o), 32'(r[0]));
    chk("tc_one", 32'(tc_o), 32'(r[0]));
  endtask

  task automatic step_clk();
    @(posedge clk);
    m_b = nxt(m_b, 2, 15, din);
    m_d = nxt(m_d, 2, 9, din);
    m_o = nxt(m_o, 1, 15, {4'h0, din[3:0]});
    @(negedge clk);
    chk_q();
  endtask

  task automatic load(input logic [7:0] v);
    din    = v;
    n_load = 1'b0;
    step_clk();
    n_load = 1'b1;
  endtask

  logic [3:0] seq6 [7];

  initial begin
    n_clr  = 1'b0;
    n_sclr = 1'b1;
    n_load = 1'b1;
    enp    = 1'b0;
    ent    = 1'b0;
    up     = 1'b1;
    din    = 8'h00;
    m_b = 0; m_d = 0; m_o = 0;
    @(negedge clk);
    @(negedge clk);
    chk_q();
    chk("rst_q_bin", 32'(q_b), 32'h00);
    n_clr = 1'b1;

    // async clear between edges
    load(8'h5A);
    chk("ld_5a", 32'(q_b), 32'h5A);
    #2 n_clr = 1'b0;
    #1 chk("aclr_now", 32'(q_b), 32'h00);
    m_b = 0; m_d = 0; m_o = 0;
    @(posedge clk);
    #1 chk("aclr_hold", 32'(q_b), 32'h00);
    @(negedge clk);
    n_clr = 1'b1;

    // binary cascade
    load(8'h0E);
    enp = 1'b1; ent = 1'b1; up = 1'b1;
    step_clk();
    chk("b_0f", 32'(q_b), 32'h0F);
    chk_comb();
    chk("b_rco0", 32'(rco_b[0]), 32'h1);
    step_clk();
    chk("b_10", 32'(q_b), 32'h10);
    load(8'hFF);
    din = 8'h00;
    chk_comb();
    chk("b_tc_ff", 32'(tc_b), 32'h1);
    step_clk();
    chk("b_wrap", 32'(q_b), 32'h00);

    // decade down
    up = 1'b0;
    load(8'h10);
    chk_comb();
    chk("d_rco0", 32'(rco_d[0]), 32'h1);
    step_clk();
    chk("d_09", 32'(q_d), 32'h09);
    load(8'h00);
    din = 8'h99;
    chk_comb();
    chk("d_tc_00", 32'(tc_d), 32'h1);
    step_clk();
    chk("d_99", 32'(q_d), 32'h99);

    // priority
    up = 1'b1;
    n_sclr = 1'b0; n_load = 1'b0; din = 8'h37;
    step_clk();
    chk("pri_sclr", 32'(q_b), 32'h00);
    n_sclr = 1'b1;
    step_clk();
    chk("pri_load", 32'(q_b), 32'h37);
    n_load = 1'b1;

    // enable gating
    ent = 1'b0;
    chk_comb();
    chk("ent0_rco", 32'(rco_b), 32'h0);
    step_clk();
    chk("ent0_hold", 32'(q_b), 32'h37);
    load(8'h0F);
    enp = 1'b0; ent = 1'b1;
    chk_comb();
    chk("enp0_rco0", 32'(rco_b[0]), 32'h1);
    step_clk();
    chk("enp0_hold", 32'(q_b), 32'h0F);
    load(8'h0C);
    enp = 1'b1;
    chk_comb();
    chk("nbcd_rco0", 32'(rco_d[0]), 32'h0);
    step_clk();
    chk("nbcd_up", 32'(q_d), 32'h00);

    // single digit from A: reload vs wrap
    if (AR) seq6 = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'hA, 4'hB};
    else    seq6 = '{4'hB, 4'hC, 4'hD, 4'hE, 4'hF, 4'h0, 4'h1};
    load(8'h0A);
    for (int k = 0; k < 7; k++) begin
      step_clk();
      chk("one_seq", 32'(q_o), 32'(seq6[k]));
      #1 chk("one_tc", 32'(tc_o), 32'(seq6[k] == 4'hF));
    end

    // randomized run
    for (int n = 0; n < 500; n++) begin
      n_sclr = ($urandom_range(0, 15) != 0);
      n_load = ($urandom_range(0, 7) != 0);
      enp    = ($urandom_range(0, 3) != 0);
      ent    = ($urandom_range(0, 3) != 0);
      up     = 1'($urandom_range(0, 1));
      din    = 8'($urandom);
      chk_comb();
      step_clk();
    end

    $display("[TB] %0d tests run, %0d failed",
             n_tests, n_fail);
    $finish;
  end

endmodule
